// File: rtl/digest_capture.sv
// digest_capture: shadows a window of register-file write-backs, freezes on halt or watchdog, streams the digest out
module digest_capture #(
  parameter int NUM_WORDS   = 8,
  parameter int WORD_W      = 32,
  parameter int FIRST_REG   = 10,
  parameter int HALT_CYCLES = 4,
  parameter int MAX_CYCLES  = 1000000,
  parameter int CNT_W       = 32
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        rf_we,
  input  logic [4:0]                  rf_waddr,
  input  logic [WORD_W-1:0]           rf_wdata,
  input  logic [31:0]                 pc,
  input  logic                        rearm,
  output logic                        done,
  output logic                        timeout,
  output logic [CNT_W-1:0]            cycle_count,
  output logic [NUM_WORDS*WORD_W-1:0] digest,
  output logic                        out_valid,
  output logic [WORD_W-1:0]           out_data,
  output logic                        out_last,
  input  logic                        out_ready
);
  localparam int IW = NUM_WORDS > 1 ? $clog2(NUM_WORDS) : 1;
  localparam int SW = $clog2(HALT_CYCLES + 1);
  localparam logic [1:0] RUN = 2'd0, DONE = 2'd1, DRAINED = 2'd2, TMO = 2'd3;
  logic [1:0]        state;
  logic [WORD_W-1:0] words [NUM_WORDS];
  logic [CNT_W-1:0]  cnt;
  logic [SW-1:0]     same_cnt;
  logic [31:0]       last_pc;
  logic [IW-1:0]     idx;
  logic              same, halt, tmo, last, run;
  assign run  = state == RUN;
  assign same = pc == last_pc;
  assign halt = same && same_cnt == SW'(HALT_CYCLES - 2);
  assign tmo  = cnt + 1'b1 == CNT_W'(MAX_CYCLES);
  assign last = idx == IW'(NUM_WORDS - 1);
  assign done        = state == DONE || state == DRAINED;
  assign timeout     = state == TMO;
  assign out_valid   = state == DONE;
  assign out_data    = words[idx];
  assign out_last    = out_valid && last;
  assign cycle_count = cnt;
  for (genvar i = 0; i < NUM_WORDS; i++) begin : g_dig
    assign digest[(NUM_WORDS-1-i)*WORD_W +: WORD_W] = words[i];
  end
  always_ff @(posedge clk)
    if (reset || (!run && rearm))
      for (int k = 0; k < NUM_WORDS; k++) words[k] <= '0;
    else if (run && rf_we)
      for (int k = 0; k < NUM_WORDS; k++)
        if (rf_waddr == 5'(FIRST_REG + k)) words[k] <= rf_wdata;
  // halt takes priority over a watchdog expiring on the same edge
  always_ff @(posedge clk)
    if (reset) begin
      state    <= RUN;
      cnt      <= '0;
      same_cnt <= '0;
      last_pc  <= '0;
      idx      <= '0;
    end else if (run) begin
      last_pc  <= pc;
      same_cnt <= same ? (&same_cnt ? same_cnt : same_cnt + 1'b1) : '0;
      cnt      <= cnt + 1'b1;
      state    <= halt ? DONE : tmo ? TMO : RUN;
    end else if (rearm) begin
      state    <= RUN;
      cnt      <= '0;
      same_cnt <= '0;
      last_pc  <= pc;
      idx      <= '0;
    end else if (out_valid && out_ready) begin
      idx   <= last ? idx : idx + 1'b1;
      state <= last ? DRAINED : DONE;
    end
endmodule

// File: tb/tb_digest_capture.sv
// tb_digest_capture: directed scoreboard bench for digest_capture
module tb_digest_capture;
  logic clk = 0, reset = 1, rf_we = 0, rearm = 0, out_ready = 0;
  logic [4:0] rf_waddr = 0;
  logic [31:0] rf_wdata = 0, pc = 0;
  logic done, timeout, out_valid, out_last;
  logic [31:0] cycle_count, out_data;
  logic [255:0] digest;
  logic b_done, b_timeout, b_out_valid, b_out_last;
  logic [31:0] b_cycle_count, b_out_data;
  logic [127:0] b_digest;
  int checks = 0, failures = 0, ecnt = 0;
  bit run = 0;
  logic [31:0] exp_w [8];
  logic [31:0] q [$];
  logic [31:0] p = 32'h200;

  digest_capture #(.MAX_CYCLES(20)) dut (
    .clk(clk), .reset(reset), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .pc(pc),
    .rearm(rearm), .done(done), .timeout(timeout), .cycle_count(cycle_count), .digest(digest),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_ready(out_ready));

  digest_capture #(.NUM_WORDS(4), .FIRST_REG(5), .MAX_CYCLES(20)) dut_b (
    .clk(clk), .reset(reset), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .pc(pc),
    .rearm(rearm), .done(b_done), .timeout(b_timeout), .cycle_count(b_cycle_count), .digest(b_digest),
    .out_valid(b_out_valid), .out_data(b_out_data), .out_last(b_out_last), .out_ready(out_ready));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_model();
    for (int i = 0; i < 8; i++) exp_w[i] = '0;
  endtask

  function automatic logic [255:0] dig();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[(7-i)*32 +: 32] = exp_w[i];
    return r;
  endfunction

  task automatic step(input logic we, input int a, input logic [31:0] d, input bit hold);
    rf_we = we;
    rf_waddr = 5'(a);
    rf_wdata = d;
    if (!hold) p += 4;
    pc = hold ? 32'h100 : p;
    if (run) begin
      ecnt++;
      if (we && a >= 10 && a <= 17) exp_w[a-10] = d;
    end
    tick();
    rf_we = 0;
  endtask

  task automatic do_rearm();
    rearm = 1;
    run = 0;
    tick();
    rearm = 0;
    ecnt = 0;
    run = 1;
    clear_model();
  endtask

  task automatic push_all();
    for (int i = 0; i < 8; i++) q.push_back(exp_w[i]);
  endtask

  task automatic stream(input int n, input bit tog);
    int c = 0;
    while (n > 0 && c < 40) begin
      out_ready = tog ? ~c[0] : 1'b1;
      chk("str_valid", out_valid, 1);
      chk("str_data", out_data, q[0]);
      chk("str_last", out_last, q.size() == 1);
      tick();
      if (out_ready) begin
        void'(q.pop_front());
        n--;
      end
      c++;
    end
    out_ready = 0;
  endtask

  initial begin
    clear_model();
    tick();
    tick();
    chk("rst_done", done, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_cnt", cycle_count, 0);
    chk("rst_digest", digest, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_last", out_last, 0);
    chk("rst_data", out_data, 0);
    reset = 0;
    ecnt = 0;
    run = 1;
    // basic capture then halt on a 4-cycle PC self-loop
    for (int k = 1; k <= 8; k++) begin
      step(1, 9 + k, 32'h1111_1111 * k, 0);
      chk("cap_digest", digest, dig());
    end
    for (int h = 0; h < 4; h++) begin
      chk("pre_halt_done", done, 0);
      step(0, 0, 0, 1);
    end
    run = 0;
    chk("halt_done", done, 1);
    chk("halt_timeout", timeout, 0);
    chk("halt_cnt", cycle_count, ecnt);
    chk("halt_digest", digest, dig());
    push_all();
    stream(8, 0);
    chk("drained_valid", out_valid, 0);
    chk("drained_done", done, 1);
    chk("drained_cnt", cycle_count, ecnt);
    // rearm, out-of-window writes, write on the halt edge, write after done
    do_rearm();
    chk("rearm_digest", digest, 0);
    chk("rearm_cnt", cycle_count, 0);
    chk("rearm_done", done, 0);
    chk("rearm_valid", out_valid, 0);
    step(1, 9, 32'hDEAD_BEEF, 0);
    step(1, 18, 32'hDEAD_BEEF, 0);
    step(1, 0, 32'hDEAD_BEEF, 0);
    step(1, 10, 32'h5, 0);
    chk("window_digest", digest, {32'h5, 224'h0});
    for (int h = 0; h < 3; h++) step(0, 0, 0, 1);
    step(1, 12, 32'hABCD, 1);
    run = 0;
    chk("edge_done", done, 1);
    chk("edge_digest", digest, dig());
    chk("edge_cnt", cycle_count, ecnt);
    step(1, 12, 32'h9999, 1);
    chk("late_digest", digest, dig());
    chk("late_cnt", cycle_count, ecnt);
    push_all();
    stream(8, 1);
    chk("toggle_drained", out_valid, 0);
    // watchdog expiry with a write on the same edge
    do_rearm();
    for (int t = 0; t < 19; t++) step(0, 0, 0, 0);
    chk("pre_tmo", timeout, 0);
    chk("pre_tmo_cnt", cycle_count, ecnt);
    step(1, 11, 32'h77, 0);
    run = 0;
    chk("tmo", timeout, 1);
    chk("tmo_done", done, 0);
    chk("tmo_cnt", cycle_count, ecnt);
    chk("tmo_digest", digest, dig());
    chk("tmo_valid", out_valid, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    chk("tmo_hold_cnt", cycle_count, ecnt);
    chk("tmo_hold_valid", out_valid, 0);
    // halt and watchdog on the same edge
    do_rearm();
    for (int t = 0; t < 16; t++) step(t < 8, 10 + t, 32'hA0 + t, 0);
    for (int h = 0; h < 4; h++) step(0, 0, 0, 1);
    run = 0;
    chk("tie_done", done, 1);
    chk("tie_timeout", timeout, 0);
    chk("tie_cnt", cycle_count, ecnt);
    chk("tie_digest", digest, dig());
    // reset in the middle of the stream
    push_all();
    stream(3, 0);
    q.delete();
    reset = 1;
    tick();
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_last", out_last, 0);
    chk("mid_rst_data", out_data, 0);
    chk("mid_rst_cnt", cycle_count, 0);
    chk("mid_rst_digest", digest, 0);
    reset = 0;
    ecnt = 0;
    run = 1;
    clear_model();
    // narrow window x5..x8 on the second instance
    step(1, 4, 32'h1, 0);
    chk("run_after_rst", cycle_count, ecnt);
    step(1, 5, 32'h55, 0);
    step(1, 6, 32'h66, 0);
    step(1, 7, 32'h77, 0);
    step(1, 8, 32'h88, 0);
    step(1, 9, 32'h99, 0);
    for (int h = 0; h < 4; h++) step(0, 0, 0, 1);
    run = 0;
    chk("b_done", b_done, 1);
    chk("b_digest", b_digest, {32'h55, 32'h66, 32'h77, 32'h88});
    chk("b_cnt", b_cycle_count, ecnt);
    chk("b_data", b_out_data, 32'h55);
    chk("b_last", b_out_last, 0);
    chk("a_digest", digest, dig());
    chk("a_done", done, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
